bcd_timer_ctrl: RTL and testbench

Sequencing controller for a cascaded chain of BCD decade counters forming a multi-digit up/down stopwatch/timer. Generates the prescaled count-enable tick, direction, preset load and clear strobes for the chain. Watches the chain's aggregate terminal count to stop at the end of the range, and raises an alarm. Sits between the board push-buttons (already synchronized) and the digit counter chain feeding the display.

---
 rtl/bcd_timer_ctrl.sv | 128 ++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a cascaded BCD decade-counter chain (stopwatch/timer).
// Produces the prescaled count enable, direction, preset load and clear strobes, and raises an alarm at end of range.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; cnt_up tracks ~btn_mode
//   LOAD  | one-cycle parallel load of preset into the chain
//   RUN   | prescaler running, cnt_ce pulsed once per DIV cycles
//   PAUSE | prescaler frozen, phase kept for resume
//   DONE  | chain at terminal count, alarm held until acknowledged
module bcd_timer_ctrl #(
    parameter int DIV    = 50000,
    parameter int DIGITS = 4
) (
    input  logic                  sys_clk,
    input  logic                  clr,
    input  logic                  btn_start,
    input  logic                  btn_mode,
    input  logic                  btn_reset,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  chain_tc,
    output logic                  cnt_ce,
    output logic                  cnt_up,
    output logic                  cnt_load,
    output logic [4*DIGITS-1:0]   cnt_di,
    output logic                  cnt_clr,
    output logic [2:0]            state,
    output logic                  alarm
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          st;
    logic [PW-1:0]   presc;
    logic            start_prev;
    logic            start_edge;
    logic            presc_last;

    assign start_edge = btn_start & ~start_prev;
    assign presc_last = (presc == PRE_LAST);
    assign state      = st;

    always_ff @(posedge sys_clk or posedge clr) begin
        if (clr) begin
            st         <= IDLE;
            presc      <= '0;
            start_prev <= 1'b1;
            cnt_ce     <= 1'b0;
            cnt_load   <= 1'b0;
            cnt_clr    <= 1'b0;
            alarm      <= 1'b0;
            cnt_up     <= 1'b1;
            cnt_di     <= '0;
        end else begin
            start_prev <= btn_start;
            cnt_ce     <= 1'b0;
            cnt_load   <= 1'b0;
            cnt_clr    <= 1'b0;

            // Direction only follows the mode switch while idle; frozen once a run starts.
            if (st == IDLE)
                cnt_up <= ~btn_mode;

            if (btn_reset) begin
                cnt_clr <= 1'b1;
                st      <= IDLE;
                presc   <= '0;
                alarm   <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        presc <= '0;
                        if (start_edge) begin
                            if (btn_mode) begin
                                cnt_di   <= preset;
                                cnt_load <= 1'b1;
                                st       <= LOAD;
                            end else begin
                                st <= RUN;
                            end
                        end
                    end
                    LOAD: begin
                        presc <= '0;
                        st    <= RUN;
                    end
                    RUN: begin
                        if (start_edge) begin
                            st <= PAUSE;
                        end else if (presc_last) begin
                            presc <= '0;
                            // Stop rather than wrap: the chain saturates at its terminal count.
                            if (chain_tc) begin
                                st    <= DONE;
                                alarm <= 1'b1;
                            end else begin
                                cnt_ce <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (start_edge)
                            st <= RUN;
                    end
                    DONE: begin
                        if (start_edge) begin
                            alarm <= 1'b0;
                            st    <= IDLE;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Scoreboard bench for bcd_timer_ctrl: stimulus pushes expected output events, a monitor pops and compares them.
// Includes a behavioural model of the external BCD chain that drives chain_tc.
module tb_bcd_timer_ctrl;

    localparam int DIV    = 4;
    localparam int DIGITS = 4;

    logic        sys_clk;
    logic        clr;
    logic        btn_start;
    logic        btn_mode;
    logic        btn_reset;
    logic [15:0] preset;
    logic        chain_tc;
    logic        cnt_ce;
    logic        cnt_up;
    logic        cnt_load;
    logic [15:0] cnt_di;
    logic        cnt_clr;
    logic [2:0]  state;
    logic        alarm;

    bcd_timer_ctrl #(.DIV(DIV), .DIGITS(DIGITS)) dut (
        .sys_clk   (sys_clk),
        .clr       (clr),
        .btn_start (btn_start),
        .btn_mode  (btn_mode),
        .btn_reset (btn_reset),
        .preset    (preset),
        .chain_tc  (chain_tc),
        .cnt_ce    (cnt_ce),
        .cnt_up    (cnt_up),
        .cnt_load  (cnt_load),
        .cnt_di    (cnt_di),
        .cnt_clr   (cnt_clr),
        .state     (state),
        .alarm     (alarm)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic        ce;
        logic        load;
        logic        clrs;
        logic        alarm;
        logic        up;
        logic [15:0] di;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_err = 0;
    int  chain_cnt = 0;
    bit  mon_en = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[3:0]) + 10 * int'(v[7:4]) + 100 * int'(v[11:8]) + 1000 * int'(v[15:12]);
    endfunction

    // External chain: clear, load, or count on the strobes it sees at each edge.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (cnt_clr)
            chain_cnt <= 0;
        else if (cnt_load)
            chain_cnt <= bcd2int(cnt_di);
        else if (cnt_ce)
            chain_cnt <= cnt_up ? chain_cnt + 1 : chain_cnt - 1;
    end

    assign chain_tc = cnt_up ? (chain_cnt == 9999) : (chain_cnt == 0);

    task automatic push(input int t, input int s, input bit ce, input bit ld, input bit cl,
                        input bit al, input bit up, input logic [15:0] di);
        ev_t e;
        e.cyc = t; e.st = 3'(s); e.ce = ce; e.load = ld; e.clrs = cl;
        e.alarm = al; e.up = up; e.di = di;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: an event is any strobe high or any change of state/alarm/cnt_up/cnt_di.
    initial begin
        ev_t o;
        ev_t e;
        ev_t prev;
        prev.cyc = 0; prev.st = 3'd0; prev.ce = 1'b0; prev.load = 1'b0; prev.clrs = 1'b0;
        prev.alarm = 1'b0; prev.up = 1'b1; prev.di = 16'h0;
        forever begin
            @(negedge sys_clk);
            if (mon_en) begin
                o.cyc = cyc; o.st = state; o.ce = cnt_ce; o.load = cnt_load; o.clrs = cnt_clr;
                o.alarm = alarm; o.up = cnt_up; o.di = cnt_di;
                if (o.ce || o.load || o.clrs || o.st !== prev.st || o.alarm !== prev.alarm ||
                    o.up !== prev.up || o.di !== prev.di) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event cyc=%0d st=%0d ce=%0b load=%0b clr=%0b alarm=%0b up=%0b di=%h",
                                 o.cyc, o.st, o.ce, o.load, o.clrs, o.alarm, o.up, o.di);
                    end else begin
                        e = exp_q.pop_front();
                        if (o.cyc !== e.cyc || o.st !== e.st || o.ce !== e.ce || o.load !== e.load ||
                            o.clrs !== e.clrs || o.alarm !== e.alarm || o.up !== e.up || o.di !== e.di) begin
                            n_err++;
                            $display("FAIL event got: cyc=%0d st=%0d ce=%0b load=%0b clr=%0b alarm=%0b up=%0b di=%h | exp: cyc=%0d st=%0d ce=%0b load=%0b clr=%0b alarm=%0b up=%0b di=%h",
                                     o.cyc, o.st, o.ce, o.load, o.clrs, o.alarm, o.up, o.di,
                                     e.cyc, e.st, e.ce, e.load, e.clrs, e.alarm, e.up, e.di);
                        end
                    end
                end
                prev = o;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    task automatic press();
        btn_start = 1'b1;
        @(negedge sys_clk);
        btn_start = 1'b0;
    endtask

    int c, d, f, g, k, m, n;

    initial begin
        clr = 1'b1; btn_start = 1'b1; btn_mode = 1'b0; btn_reset = 1'b0; preset = 16'h0;
        repeat (3) @(negedge sys_clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ce", 32'(cnt_ce), 32'd0);
        chk("rst_load", 32'(cnt_load), 32'd0);
        chk("rst_clr", 32'(cnt_clr), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_up", 32'(cnt_up), 32'd1);
        chk("rst_di", 32'(cnt_di), 32'd0);

        // Start held through reset release must not be seen as an edge.
        clr = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("held_start_state", 32'(state), 32'd0);
        chk("held_start_load", 32'(cnt_load), 32'd0);
        btn_start = 1'b0;
        @(negedge sys_clk);

        // Up mode: RUN next cycle, cnt_ce every DIV cycles.
        c = cyc;
        push(c + 1,  2, 0, 0, 0, 0, 1, 16'h0);
        push(c + 5,  2, 1, 0, 0, 0, 1, 16'h0);
        push(c + 9,  2, 1, 0, 0, 0, 1, 16'h0);
        push(c + 13, 2, 1, 0, 0, 0, 1, 16'h0);
        press();

        // Pause with prescaler at 2, hold 10 cycles, resume: ce 2 cycles later.
        goto(c + 15);
        push(c + 16, 3, 0, 0, 0, 0, 1, 16'h0);
        press();
        goto(c + 26);
        d = cyc;
        push(d + 1, 2, 0, 0, 0, 0, 1, 16'h0);
        push(d + 3, 2, 1, 0, 0, 0, 1, 16'h0);
        press();

        // Soft reset coinciding with start edge and a tick.
        goto(d + 6);
        btn_reset = 1'b1; btn_start = 1'b1;
        push(d + 7, 0, 0, 0, 1, 0, 1, 16'h0);
        @(negedge sys_clk);
        btn_reset = 1'b0; btn_start = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Down mode from preset 3: load, three ces, then DONE at the next tick.
        btn_mode = 1'b1; preset = 16'h0003;
        push(cyc + 1, 0, 0, 0, 0, 0, 0, 16'h0);
        repeat (2) @(negedge sys_clk);
        f = cyc;
        push(f + 1,  1, 0, 1, 0, 0, 0, 16'h0003);
        push(f + 2,  2, 0, 0, 0, 0, 0, 16'h0003);
        push(f + 6,  2, 1, 0, 0, 0, 0, 16'h0003);
        push(f + 10, 2, 1, 0, 0, 0, 0, 16'h0003);
        push(f + 14, 2, 1, 0, 0, 0, 0, 16'h0003);
        push(f + 18, 4, 0, 0, 0, 1, 0, 16'h0003);
        press();
        goto(f + 4);
        btn_mode = 1'b0;
        goto(f + 22);
        chk("done_state", 32'(state), 32'd4);
        chk("done_alarm", 32'(alarm), 32'd1);

        // DONE acknowledge after mode toggle: back to IDLE, cnt_up follows one cycle later.
        btn_mode = 1'b1;
        @(negedge sys_clk);
        btn_mode = 1'b0;
        @(negedge sys_clk);
        g = cyc;
        push(g + 1, 0, 0, 0, 0, 0, 0, 16'h0003);
        push(g + 2, 0, 0, 0, 0, 0, 1, 16'h0003);
        press();

        // Down mode with preset 0: straight to DONE with no cnt_ce.
        goto(g + 4);
        k = cyc;
        btn_mode = 1'b1; preset = 16'h0000;
        push(k + 1, 0, 0, 0, 0, 0, 0, 16'h0003);
        repeat (2) @(negedge sys_clk);
        m = cyc;
        push(m + 1, 1, 0, 1, 0, 0, 0, 16'h0000);
        push(m + 2, 2, 0, 0, 0, 0, 0, 16'h0000);
        push(m + 6, 4, 0, 0, 0, 1, 0, 16'h0000);
        press();

        // Soft reset held two cycles from DONE: cnt_clr re-asserted each cycle.
        goto(m + 9);
        n = cyc;
        btn_reset = 1'b1;
        push(n + 1, 0, 0, 0, 1, 0, 0, 16'h0000);
        push(n + 2, 0, 0, 0, 1, 0, 0, 16'h0000);
        repeat (2) @(negedge sys_clk);
        btn_reset = 1'b0;
        repeat (4) @(negedge sys_clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_events got=%0d exp=0 next_cyc=%0d", exp_q.size(), exp_q[0].cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
